vlan_untagger: RTL and testbench
================================

# vlan_untagger

RX-path counterpart of the VIU TX tagger. It sits between the CMAC RX stream and the network stack. It detects an 802.1Q tag at byte offset 12 and strips the 4 tag bytes, closing the gap across all beats of the frame. It decodes the VID into the 14-bit route word for the RX gateway and drops tagged frames addressed to another node. Untagged frames pass through unchanged with a zero route.

## Interface
- DATA_WIDTH, 512: AXI-Stream data width; byte n = tdata[8n+7:8n]; BYTES = DATA_WIDTH/8 = 64.
- aclk  in  1  clock; single clock domain.
- areset  in  1  reset, asynchronous and active-high.
- local_node_id  in  2  this FPGA's node ID; quasi-static.
- filter_en  in  1  when 1, drop tagged frames whose dst_node_id != local_node_id; sampled at the head beat.
- s_axis_tdata/tkeep/tlast/tvalid  in  512/64/1/1  tagged or untagged frames from CMAC; tkeep contiguous from byte 0.
- s_axis_tready  out  1
- m_axis_tdata/tkeep/tlast/tvalid  out  512/64/1/1  untagged frames to the stack.
- m_axis_tready  in  1
- route_in  out  14  [13:12] src_node, [11:8] src_vfpga, [7:6] dst_node, [5:2] dst_vfpga, [1:0] = 0.
- route_tagged  out  1  current/last frame carried a tag.
- route_valid  out  1  high from head-beat acceptance until the last output beat is accepted.
- drop_cnt  out  32  count of frames dropped by the filter; saturates at 0xFFFFFFFF.

## Operation
- Tag detect on head beat, combinational: byte12 == 0x81, byte13 == 0x00, and tkeep[15:0] all ones. A head beat that fails any of these is untagged, runts included.
- VID = {byte14[3:0], byte15}. route_in = {VID[11:10], VID[9:6], VID[5:4], VID[3:0], 2'b00}. PCP and DEI are ignored.
- States: ST_HEAD, ST_PASS, ST_STRIP, ST_FLUSH, ST_DROP.
- ST_HEAD, untagged head:
  - Pass-through: m = s; s_tready = m_tready.
  - On handshake: route_in <= 0, route_tagged <= 0, route_valid <= 1.
  - Next state: ST_PASS if !tlast, else stay in ST_HEAD with route_valid cleared.
- ST_HEAD, tagged head, forward case (filter_en == 0 or dst_node match):
  - s_tready = 1, m_tvalid = 0.
  - hold[0..59] <= {bytes 0..11, bytes 16..63}; hold_keep likewise.
  - route_in, route_tagged <= 1, route_valid <= 1 latched.
  - Next state: ST_FLUSH if tlast, else ST_STRIP.
- ST_HEAD, tagged head, drop case: s_tready = 1, no output, drop_cnt++. Next state: ST_DROP if !tlast, else ST_HEAD.
- ST_PASS: m = s; s_tready = m_tready. Return to ST_HEAD on the tlast handshake.
- ST_STRIP: m_tvalid = s_tvalid; s_tready = m_tready.
  - Output beat = hold[0..59] ++ s bytes 0..3; tkeep = hold_keep[59:0] ++ s_tkeep[3:0].
  - On handshake: hold[0..59] <= s bytes 4..63.
  - If s_tlast and s_tkeep[63:4] == 0: m_tlast = 1, go to ST_HEAD.
  - If s_tlast otherwise: m_tlast = 0, go to ST_FLUSH.
- ST_FLUSH: s_tready = 0, m_tvalid = 1.
  - Output = hold in bytes 0..59, bytes 60..63 = 0; tkeep = {4'b0, hold_keep}; m_tlast = 1.
  - On the m handshake go to ST_HEAD.
- ST_DROP: s_tready = 1, m_tvalid = 0. Go to ST_HEAD on tlast.
- Output bytes with tkeep = 0 are driven 0.
- route_* hold their values until the next head beat; route_valid falls on the last output handshake. Dropped frames do not assert route_valid.

## Timing
- Reset (async assert, sync release):
  - state = ST_HEAD; hold = 0; route_in = 0; route_tagged = 0; route_valid = 0; drop_cnt = 0.
  - m_axis_tvalid = 0 and s_axis_tready = 0 while areset is high.
- Reset mid-frame aborts the frame immediately; no partial flush.
- Latency:
  - Untagged: 0 cycles, combinational.
  - Tagged: first output beat is emitted in the cycle the 2nd input beat is valid. For a single-beat frame, it is emitted the cycle after the head handshake.
- Beat count:
  - Tagged frame of L bytes (L >= 18) → L−4 output bytes in ceil((L−4)/64) beats.
  - One extra FLUSH beat occurs exactly when the last input beat has bytes beyond 3.
- Throughput: one beat/cycle in ST_PASS and ST_STRIP. There is one bubble per tagged frame at the head, and one input stall cycle in ST_FLUSH.
- m_axis_* stay stable while m_tvalid && !m_tready in ST_FLUSH. In the pass states they follow the s side, which must itself be AXI-stable.

## Test plan
- Untagged 64 B frame, byte12..13 = 0x0800 → identical single output beat same cycle; route_in = 0, route_tagged = 0.
- Tagged 64 B single beat, VID = 0x9A5, local_node_id = 2 → ST_FLUSH beat of 60 B: bytes 0..11 = MACs, bytes 12..13 = original bytes 16..17, tkeep = 0x0FFF_FFFF_FFFF_FFFF, tlast; route_in = 0x2694.
- Tagged 130 B (beats 64/64/2 B) → output 126 B as 64 + 62 B. The second output beat is the last one; it takes the 2nd input's bytes 4..63 plus the 3rd input's bytes 0..1; no FLUSH.
- Tagged 128 B (64/64) → output 64 + 60 B, the second beat via ST_FLUSH; random m_tready backpressure gives a byte-exact stream.
- filter_en = 1, local_node_id = 1, VID dst_node = 3, 3-beat frame → no m_tvalid, all 3 beats accepted, drop_cnt = 1, route_valid stays 0.
- areset pulsed during the 2nd beat of a tagged frame → outputs zero immediately; the next untagged frame passes correctly.

Source files
------------

// File: rtl/vlan_untagger.sv
// vlan_untagger: strips an 802.1Q tag at byte 12, decodes the VID into a route word and filters foreign-node frames
module vlan_untagger #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [1:0]              local_node_id,
  input  logic                    filter_en,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [13:0]             route_in,
  output logic                    route_tagged,
  output logic                    route_valid,
  output logic [31:0]             drop_cnt
);
  localparam int BYTES = DATA_WIDTH / 8;
  typedef enum logic [2:0] {ST_HEAD, ST_PASS, ST_STRIP, ST_FLUSH, ST_DROP} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-33:0] hold;
  logic [BYTES-5:0] hold_keep;
  logic [DATA_WIDTH-1:0] raw_data;
  logic [BYTES-1:0] raw_keep;
  logic mv, sr, ml, s_hs, m_hs, head_hs, is_tag, fwd;
  logic [11:0] vid;
  assign is_tag = s_axis_tdata[103:96] == 8'h81 && s_axis_tdata[111:104] == 8'h00 && &s_axis_tkeep[15:0];
  assign vid = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
  assign fwd = !filter_en || vid[5:4] == local_node_id;
  assign s_hs = s_axis_tvalid && sr;
  assign m_hs = mv && m_axis_tready;
  assign head_hs = state == ST_HEAD && s_hs;
  assign s_axis_tready = sr && !areset;
  assign m_axis_tvalid = mv && !areset;
  assign m_axis_tkeep = raw_keep;
  assign m_axis_tlast = ml;
  always_comb begin
    state_nxt = state;
    mv = s_axis_tvalid;
    sr = m_axis_tready;
    ml = s_axis_tlast;
    raw_data = s_axis_tdata;
    raw_keep = s_axis_tkeep;
    case (state)
      ST_HEAD: begin
        mv = s_axis_tvalid && !is_tag;
        sr = is_tag || m_axis_tready;
        if (s_axis_tvalid && is_tag)
          state_nxt = fwd ? (s_axis_tlast ? ST_FLUSH : ST_STRIP) : (s_axis_tlast ? ST_HEAD : ST_DROP);
        else if (s_axis_tvalid && m_axis_tready && !s_axis_tlast)
          state_nxt = ST_PASS;
      end
      ST_PASS: state_nxt = s_hs && s_axis_tlast ? ST_HEAD : ST_PASS;
      ST_STRIP: begin
        raw_data = {s_axis_tdata[31:0], hold};
        raw_keep = {s_axis_tkeep[3:0], hold_keep};
        ml = s_axis_tlast && ~|s_axis_tkeep[BYTES-1:4];
        if (s_hs && s_axis_tlast) state_nxt = ml ? ST_HEAD : ST_FLUSH;
      end
      ST_FLUSH: begin
        raw_data = {32'h0, hold};
        raw_keep = {4'h0, hold_keep};
        ml = 1'b1;
        mv = 1'b1;
        sr = 1'b0;
        state_nxt = m_axis_tready ? ST_HEAD : ST_FLUSH;
      end
      ST_DROP: begin
        mv = 1'b0;
        sr = 1'b1;
        state_nxt = s_axis_tvalid && s_axis_tlast ? ST_HEAD : ST_DROP;
      end
      default: state_nxt = ST_HEAD;
    endcase
  end
  // Bytes outside tkeep are forced to zero on every path.
  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < BYTES; i++)
      m_axis_tdata[8*i+:8] = raw_keep[i] ? raw_data[8*i+:8] : 8'h00;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_HEAD;
      hold <= '0;
      hold_keep <= '0;
      route_in <= '0;
      route_tagged <= 1'b0;
      route_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (head_hs && is_tag && fwd) begin
        hold <= {s_axis_tdata[DATA_WIDTH-1:128], s_axis_tdata[95:0]};
        hold_keep <= {s_axis_tkeep[BYTES-1:16], s_axis_tkeep[11:0]};
      end else if (state == ST_STRIP && s_hs) begin
        hold <= s_axis_tdata[DATA_WIDTH-1:32];
        hold_keep <= s_axis_tkeep[BYTES-1:4];
      end
      if (head_hs && !is_tag) begin
        route_in <= '0;
        route_tagged <= 1'b0;
        route_valid <= !s_axis_tlast;
      end else if (head_hs && fwd) begin
        route_in <= {vid, 2'b00};
        route_tagged <= 1'b1;
        route_valid <= 1'b1;
      end else if (m_hs && ml) begin
        route_valid <= 1'b0;
      end
      if (head_hs && is_tag && !fwd && !(&drop_cnt)) drop_cnt <= drop_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_vlan_untagger.sv
// tb_vlan_untagger: directed and random frames checked against a byte-queue reference model
module tb_vlan_untagger;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [1:0] local_node_id = 2'd0;
  logic filter_en = 1'b0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0] s_axis_tkeep = '0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [13:0] route_in;
  logic route_tagged, route_valid;
  logic [31:0] drop_cnt;

  vlan_untagger #(.DATA_WIDTH(512)) dut (
    .aclk(aclk), .areset(areset), .local_node_id(local_node_id), .filter_en(filter_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .route_in(route_in), .route_tagged(route_tagged), .route_valid(route_valid), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  int compared = 0, mismatched = 0, exp_drops = 0;
  int beats = 0, frames_out = 0, mask_errs = 0, rv_cycles = 0;
  bit bp = 1'b0;
  logic [63:0] last_keep = '0;
  byte unsigned fr[$], exp_q[$], obytes[$];
  bit vq[$];

  function automatic bit beat_ok(input logic [511:0] d, input logic [63:0] k);
    beat_ok = (k & (k + 64'd1)) == 64'd0;
    for (int i = 0; i < 64; i++) if (!k[i] && d[8*i+:8] != 8'h00) beat_ok = 1'b0;
  endfunction

  // Output monitor: collects accepted bytes and per-frame facts.
  always @(negedge aclk) begin
    if (route_valid) rv_cycles <= rv_cycles + 1;
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      for (int i = 0; i < 64; i++) if (m_axis_tkeep[i]) obytes.push_back(m_axis_tdata[8*i+:8]);
      beats <= beats + 1;
      last_keep <= m_axis_tkeep;
      if (!beat_ok(m_axis_tdata, m_axis_tkeep)) mask_errs <= mask_errs + 1;
      if (m_axis_tlast) begin
        frames_out <= frames_out + 1;
        vq.push_back(route_valid);
      end
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mk_frame(input int len, input bit tag, input logic [11:0] vid);
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    if (tag) begin
      fr[12] = 8'h81;
      fr[13] = 8'h00;
      fr[14] = {4'($urandom), vid[11:8]};
      fr[15] = vid[7:0];
    end else if (len >= 14 && fr[12] == 8'h81 && fr[13] == 8'h00) begin
      fr[13] = 8'h01;
    end
  endtask

  task automatic pack(input int b);
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    for (int i = 0; i < 64; i++)
      if (b * 64 + i < fr.size()) begin
        s_axis_tdata[8*i+:8] = fr[b*64+i];
        s_axis_tkeep[i] = 1'b1;
      end
    s_axis_tlast = (b + 1) * 64 >= fr.size();
  endtask

  task automatic wait_hs(input string tag);
    int n;
    bit hs;
    n = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end
    chk({tag, " accept"}, hs, 1);
  endtask

  task automatic send(input bit gaps);
    int nb;
    nb = (fr.size() + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      if (gaps)
        while ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          @(posedge aclk);
          #1;
        end
      pack(b);
      s_axis_tvalid = 1'b1;
      wait_hs("beat");
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tkeep = '0;
    s_axis_tdata = '0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_out < n && t < 2000) begin
      @(posedge aclk);
      t++;
    end
    #1;
  endtask

  // Reference: a frame is tagged when it has 16+ bytes with 0x8100 at 12..13; the tag bytes vanish.
  task automatic run_frame(input bit gaps, input string tag);
    bit tg, drop;
    logic [11:0] vid;
    logic [13:0] r;
    int ob, fb, bb, mb, rb, nexp, bad;
    tg = fr.size() >= 16 && fr[12] == 8'h81 && fr[13] == 8'h00;
    vid = tg ? {fr[14][3:0], fr[15]} : 12'h0;
    r = tg ? {vid, 2'b00} : 14'h0;
    drop = tg && filter_en && vid[5:4] != local_node_id;
    exp_q.delete();
    for (int i = 0; i < fr.size(); i++) if (!drop && (!tg || i < 12 || i > 15)) exp_q.push_back(fr[i]);
    if (drop) exp_drops++;
    nexp = (exp_q.size() + 63) / 64;
    ob = obytes.size();
    fb = frames_out;
    bb = beats;
    mb = mask_errs;
    rb = rv_cycles;
    send(gaps);
    if (drop) begin
      repeat (3) @(posedge aclk);
      #1;
    end else wait_frames(fb + 1);
    chk({tag, " nbytes"}, obytes.size() - ob, exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (ob + i >= obytes.size() || obytes[ob+i] != exp_q[i])) bad = i;
    chk({tag, " first bad byte"}, bad, -1);
    chk({tag, " beats"}, beats - bb, nexp);
    chk({tag, " keep/mask"}, mask_errs - mb, 0);
    chk({tag, " drop_cnt"}, drop_cnt, exp_drops);
    chk({tag, " route_valid low"}, route_valid, 0);
    if (drop) chk({tag, " route_valid while dropping"}, rv_cycles - rb, 0);
    else begin
      chk({tag, " route_in"}, route_in, r);
      chk({tag, " route_tagged"}, route_tagged, tg);
      chk({tag, " route_valid at tlast"}, vq[fb], tg || fr.size() > 64);
    end
  endtask

  initial begin
    logic [511:0] ed;
    int len;
    bit t;
    repeat (3) @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep = '1;
    s_axis_tdata = {16{32'($urandom)}};
    @(negedge aclk);
    chk("reset m_tvalid", m_axis_tvalid, 0);
    chk("reset s_tready", s_axis_tready, 0);
    chk("reset route_in", route_in, 0);
    chk("reset route_tagged", route_tagged, 0);
    chk("reset route_valid", route_valid, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("idle s_tready", s_axis_tready, 1);
    @(posedge aclk);
    #1;

    mk_frame(64, 1'b0, 12'h0);
    fr[12] = 8'h08;
    fr[13] = 8'h00;
    pack(0);
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("untagged same-cycle valid", m_axis_tvalid, 1);
    chk("untagged data", m_axis_tdata, s_axis_tdata);
    chk("untagged keep", m_axis_tkeep, {64{1'b1}});
    chk("untagged last", m_axis_tlast, 1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    chk("untagged route_in", route_in, 0);
    chk("untagged route_tagged", route_tagged, 0);
    chk("untagged route_valid", route_valid, 0);

    local_node_id = 2'd2;
    filter_en = 1'b1;
    mk_frame(64, 1'b1, 12'h9A5);
    pack(0);
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("t64 head m_tvalid", m_axis_tvalid, 0);
    chk("t64 head s_tready", s_axis_tready, 1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    ed = '0;
    for (int i = 0; i < 60; i++) ed[8*i+:8] = i < 12 ? fr[i] : fr[i+4];
    @(negedge aclk);
    chk("t64 flush valid", m_axis_tvalid, 1);
    chk("t64 flush keep", m_axis_tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
    chk("t64 flush last", m_axis_tlast, 1);
    chk("t64 flush data", m_axis_tdata, ed);
    chk("t64 flush s_tready", s_axis_tready, 0);
    chk("t64 route_in", route_in, 14'h2694);
    chk("t64 route_tagged", route_tagged, 1);
    chk("t64 route_valid", route_valid, 1);
    @(posedge aclk);
    #1;
    chk("t64 route_valid cleared", route_valid, 0);

    filter_en = 1'b0;
    mk_frame(130, 1'b1, 12'($urandom));
    run_frame(1'b0, "t130");
    chk("t130 last keep", last_keep, 64'h3FFF_FFFF_FFFF_FFFF);
    bp = 1'b1;
    mk_frame(128, 1'b1, 12'($urandom));
    run_frame(1'b0, "t128");
    chk("t128 last keep", last_keep, 64'h0FFF_FFFF_FFFF_FFFF);
    bp = 1'b0;

    filter_en = 1'b1;
    local_node_id = 2'd1;
    mk_frame(150, 1'b1, 12'h0B3);
    run_frame(1'b0, "drop");

    filter_en = 1'b0;
    mk_frame(15, 1'b0, 12'h0);
    fr[12] = 8'h81;
    fr[13] = 8'h00;
    run_frame(1'b0, "runt");

    mk_frame(150, 1'b1, 12'($urandom));
    pack(0);
    s_axis_tvalid = 1'b1;
    wait_hs("rst head");
    pack(1);
    @(negedge aclk);
    #1;
    areset = 1'b1;
    #1;
    chk("midreset m_tvalid", m_axis_tvalid, 0);
    chk("midreset s_tready", s_axis_tready, 0);
    chk("midreset route_valid", route_valid, 0);
    chk("midreset drop_cnt", drop_cnt, 0);
    exp_drops = 0;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    mk_frame(100, 1'b0, 12'h0);
    run_frame(1'b0, "post-reset");

    for (int k = 0; k < 40; k++) begin
      filter_en = 1'($urandom_range(0, 1));
      local_node_id = 2'($urandom);
      bp = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 260);
      t = len >= 16 && $urandom_range(0, 2) != 0;
      mk_frame(len, t, 12'($urandom));
      run_frame(1'($urandom_range(0, 1)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
